mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/funrv32_pkg.sv | 47 ++++
 rtl/mem_lsu_if.sv | 38 +++
 rtl/lsu_align.sv | 31 +++
 rtl/mem_lsu.sv | 121 ++++++++++++
 tb/tb_mem_lsu.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/funrv32_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | funrv32_pkg: size encodings, LSU state type and lane helpers.      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package funrv32_pkg;

  localparam int MEM_AW_DEFAULT = 14;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_ILL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } lsu_state_t;

  function automatic logic [3:0] lane_ben(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
      SZ_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_B:    return {4{wdata[7:0]}};
      SZ_H:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  // Any address bit above the SPRAM byte range makes the access out of range.
  function automatic logic req_error(input logic [1:0] size, input logic [31:0] addr, input int aw);
    logic bad_align;
    bad_align = ((size == SZ_H) && addr[0]) || ((size == SZ_W) && (addr[1:0] != 2'b00));
    return (size == SZ_ILL) || bad_align || ((addr >> (aw + 2)) != 32'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_lsu_if: core request/response and SPRAM bus of the LSU.        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface mem_lsu_if
  import funrv32_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DEFAULT
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_wen;
  logic [3:0]        mem_ben;
  logic [31:0]       mem_rdata;

  // Environment side: the core issuing requests and the SPRAM returning data.
  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_wdata, mem_wen, mem_ben
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_wdata, mem_wen, mem_ben
  );
endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lsu_align: load data lane extraction with sign/zero extension.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module lsu_align
  import funrv32_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  off_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata_i[{off_i, 3'b000} +: 8];
    half_v = rdata_i[{off_i[1], 4'b0000} +: 16];
    data_o = rdata_i;
    case (size_i)
      SZ_B:    data_o = {{24{signed_i & byte_v[7]}}, byte_v};
      SZ_H:    data_o = {{16{signed_i & half_v[15]}}, half_v};
      default: data_o = rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_lsu: single-outstanding load/store unit in front of an SPRAM.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mem_lsu
  import funrv32_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DEFAULT
)(
  input logic      clk,
  input logic      rst,
  mem_lsu_if.slave bus
);

  lsu_state_t        state_q;
  logic              ready_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [1:0]        off_q;
  logic              err_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              mem_wen_q;
  logic [3:0]        mem_ben_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [31:0]       resp_rdata_q;

  logic              req_err;
  logic [31:0]       load_data;

  assign req_err = req_error(bus.req_size, bus.req_addr, MEM_AW);

  lsu_align u_align (
    .rdata_i  (bus.mem_rdata),
    .size_i   (size_q),
    .signed_i (signed_q),
    .off_i    (off_q),
    .data_o   (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b1;
      we_q         <= 1'b0;
      size_q       <= SZ_B;
      signed_q     <= 1'b0;
      off_q        <= 2'b00;
      err_q        <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wen_q    <= 1'b0;
      mem_ben_q    <= 4'b0000;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            state_q     <= ST_ISSUE;
            ready_q     <= 1'b0;
            we_q        <= bus.req_we;
            size_q      <= bus.req_size;
            signed_q    <= bus.req_signed;
            off_q       <= bus.req_addr[1:0];
            err_q       <= req_err;
            mem_addr_q  <= bus.req_addr[MEM_AW+1:2];
            mem_wdata_q <= lane_wdata(bus.req_size, bus.req_wdata);
            // A faulting access never touches the SPRAM, so its lanes stay dark.
            mem_wen_q   <= bus.req_we & ~req_err;
            mem_ben_q   <= req_err ? 4'b0000 : lane_ben(bus.req_size, bus.req_addr[1:0]);
          end
        end
        ST_ISSUE: begin
          mem_wen_q <= 1'b0;
          mem_ben_q <= 4'b0000;
          if (err_q || we_q) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= err_q;
            resp_rdata_q <= '0;
          end else begin
            state_q <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          state_q      <= ST_RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= load_data;
        end
        ST_RESP: begin
          state_q      <= ST_IDLE;
          ready_q      <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_wen    = mem_wen_q;
  assign bus.mem_ben    = mem_ben_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_lsu: scoreboard bench with a byte-array reference memory.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_mem_lsu;

  localparam int AW = 14;

  typedef struct {
    int          cyc;
    logic        wen;
    logic        chk;
    logic [13:0] addr;
    logic [3:0]  ben;
    logic [31:0] wdata;
  } issue_t;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  logic clk = 1'b0;
  logic rst;
  logic init_mem;
  logic mon_en;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  int   prev_acc;
  int   prev_gap;

  logic [31:0] spram [0:(1<<AW)-1];
  logic [7:0]  ref_mem [0:65535];
  issue_t      iss_q[$];
  resp_t       rsp_q[$];

  mem_lsu_if #(.MEM_AW(AW)) bus ();

  mem_lsu #(.MEM_AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int w);
    return (32'(w) * 32'h9E3779B1) ^ 32'hC3A5_0F1E;
  endfunction

  // SPRAM model: registered read, byte-enabled write.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int w = 0; w < (1 << AW); w++) spram[w] <= init_word(w);
    end else if (bus.mem_wen) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_ben[b]) spram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
    bus.mem_rdata <= spram[bus.mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at t=%0t", nm, $time);
  endtask

  always @(negedge clk) begin : monitor
    issue_t e;
    resp_t  r;
    if (mon_en) begin
      if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
        e = iss_q.pop_front();
        chk("issue_wen", 32'(bus.mem_wen), 32'(e.wen));
        if (e.chk) begin
          chk("issue_addr", 32'(bus.mem_addr), 32'(e.addr));
          chk("issue_ben", 32'(bus.mem_ben), 32'(e.ben));
          if (e.wen) chk("issue_wdata", bus.mem_wdata, e.wdata);
        end
      end else begin
        chk("idle_wen", 32'(bus.mem_wen), 32'd0);
        chk("idle_ben", 32'(bus.mem_ben), 32'd0);
      end
      if (bus.resp_valid) begin
        if (rsp_q.size() == 0) begin
          fail_now("unexpected_resp_valid");
        end else begin
          r = rsp_q.pop_front();
          chk("resp_cycle", 32'(cyc), 32'(r.cyc));
          chk("resp_err", 32'(bus.resp_err), 32'(r.err));
          chk("resp_rdata", bus.resp_rdata, r.rdata);
        end
      end else begin
        chk("quiet_err", 32'(bus.resp_err), 32'd0);
        chk("quiet_rdata", bus.resp_rdata, 32'd0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Presents one request, holding valid until accepted; expectations come
  // from the byte-array model. b2b checks the accept spacing after the
  // previous request when valid was never dropped in between.
  task automatic do_req(input bit we, input logic [1:0] sz, input bit sgn,
                        input logic [31:0] addr, input logic [31:0] wd, input bit b2b);
    int          nb;
    int          waited;
    int          acc;
    bit          err;
    logic [31:0] val;
    issue_t      ie;
    resp_t       re;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = (sz == 2'd3) || (addr >= 32'h0001_0000) || ((addr % nb) != 0);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = sz;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    waited = 0;
    while (!bus.req_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!bus.req_ready) begin
      fail_now("req_ready_timeout");
      bus.req_valid = 1'b0;
      return;
    end
    acc = cyc;
    if (b2b) chk("accept_gap", 32'(acc - prev_acc), 32'(prev_gap));
    ie.cyc  = acc + 1;
    ie.wen  = we && !err;
    ie.chk  = !err;
    ie.addr = addr[15:2];
    ie.ben  = 4'(((1 << nb) - 1) << addr[1:0]);
    for (int b = 0; b < 4; b++) ie.wdata[8*b +: 8] = wd[8*(b % nb) +: 8];
    val = 32'd0;
    if (!err && we) begin
      for (int i = 0; i < nb; i++) ref_mem[int'(addr[15:0]) + i] = wd[8*i +: 8];
    end else if (!err) begin
      for (int i = 0; i < nb; i++) val = val | (32'(ref_mem[int'(addr[15:0]) + i]) << (8*i));
      if (sgn && nb < 4 && val[8*nb-1]) val = val | ~((32'd1 << (8*nb)) - 32'd1);
    end
    re.cyc   = acc + ((err || we) ? 2 : 3);
    re.err   = err;
    re.rdata = val;
    iss_q.push_back(ie);
    rsp_q.push_back(re);
    prev_acc = acc;
    prev_gap = (err || we) ? 3 : 4;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog_timeout at t=%0t", $time);
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    logic [31:0] tmp;
    n_cmp = 0; n_bad = 0; prev_acc = 0; prev_gap = 0;
    mon_en = 1'b0; init_mem = 1'b1; rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    for (int a = 0; a < 65536; a++) begin
      tmp = init_word(a >> 2);
      ref_mem[a] = tmp[8*(a % 4) +: 8];
    end
    bus.req_valid = 1'b1;
    idle(3);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_mem_wen", 32'(bus.mem_wen), 32'd0);
    chk("rst_mem_ben", 32'(bus.mem_ben), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    bus.req_valid = 1'b0;
    rst = 1'b0; init_mem = 1'b0; mon_en = 1'b1;
    idle(1);

    // Directed: store word/byte, reload, signed/unsigned extraction.
    do_req(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    do_req(1'b1, 2'd0, 1'b0, 32'h0000_0013, 32'h0000_00A5, 1'b1);
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 1'b1);
    do_req(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h8012_3456, 1'b1);
    do_req(1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0, 1'b1);
    do_req(1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0, 1'b1);
    do_req(1'b1, 2'd2, 1'b0, 32'h0000_0020, 32'h8001_FFFF, 1'b1);
    do_req(1'b0, 2'd1, 1'b1, 32'h0000_0022, 32'h0, 1'b1);
    // Errors, issued as stores so any write leak is visible.
    do_req(1'b1, 2'd1, 1'b0, 32'h0000_0001, 32'h1111_1111, 1'b1);
    do_req(1'b1, 2'd2, 1'b0, 32'h0000_0002, 32'h2222_2222, 1'b1);
    do_req(1'b1, 2'd3, 1'b0, 32'h0000_0004, 32'h3333_3333, 1'b1);
    do_req(1'b1, 2'd2, 1'b0, 32'h0001_0000, 32'h4444_4444, 1'b1);
    do_req(1'b0, 2'd0, 1'b1, 32'h0001_0000, 32'h0, 1'b1);
    // Top word of the range.
    do_req(1'b1, 2'd2, 1'b0, 32'h0000_FFFC, 32'hCAFE_F00D, 1'b1);
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_FFFC, 32'h0, 1'b1);
    do_req(1'b0, 2'd1, 1'b1, 32'h0000_FFFE, 32'h0, 1'b1);

    // Reset during CAPTURE of a load, with a request offered during reset.
    idle(2);
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    rsp_q.delete();
    @(posedge clk); #1;
    chk("midrst_ready", 32'(bus.req_ready), 32'd1);
    chk("midrst_wen", 32'(bus.mem_wen), 32'd0);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2;
    bus.req_addr = 32'h0000_0044; bus.req_wdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    chk("postrst_ready0", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    chk("postrst_ready1", 32'(bus.req_ready), 32'd1);

    // Back-to-back loads held valid: second accepted four cycles later.
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_0044, 32'h0, 1'b0);
    do_req(1'b0, 2'd0, 1'b0, 32'h0000_0045, 32'h0, 1'b1);

    for (int n = 0; n < 300; n++) begin
      bit          we, sgn;
      logic [1:0]  sz;
      logic [31:0] a, wd;
      int          g;
      we  = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) != 0) a = a & ~((sz == 2'd1) ? 32'd1 : (sz == 2'd2) ? 32'd3 : 32'd0);
      if ($urandom_range(0, 9) == 0) a = a | (32'd1 << $urandom_range(16, 31));
      wd  = $urandom;
      g   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      if (g > 0) idle(g);
      do_req(we, sz, sgn, a, wd, g == 0);
    end

    for (int k = 0; k < 20 && (rsp_q.size() > 0 || iss_q.size() > 0); k++) idle(1);
    if (rsp_q.size() > 0 || iss_q.size() > 0) fail_now("pending_expectations");
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
